// File: rtl/cam_window_capture.sv
// OV7670 byte stream -> RGB565, windowed/decimated frame-buffer writes; optional CAM_TESTPATTERN_EN pattern source.
// Latency: write strobe 1 cycle after the registered second byte of a pixel.
// Backpressure: none, the camera cannot stall; buffer port must accept one write per cycle.
module cam_window_capture #(
   parameter int SRC_W  = 640,
   parameter int SRC_H  = 480,
   parameter int WIN_W  = 256,
   parameter int WIN_H  = 256,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic [7:0]        cam_data,
   input  logic              write,
   input  logic [9:0]        win_x0,
   input  logic [8:0]        win_y0,
   input  logic [1:0]        dec_shift,
`ifdef CAM_TESTPATTERN_EN
   input  logic [1:0]        tp_mode,
`endif
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic              frame_done,
   output logic              frame_valid,
   output logic              line_err
);

   localparam logic [9:0]  X_MAX   = 10'(SRC_W - 1);
   localparam logic [8:0]  Y_MAX   = 9'(SRC_H - 1);
   localparam logic [31:0] WIN_W_U = 32'(WIN_W);
   localparam logic [31:0] WIN_H_U = 32'(WIN_H);

   typedef enum logic [1:0] {SYNC, VBLANK, FRAME} state_t;
   state_t state_q, state_d;

   logic       vs_r, vs_q, hr_r, hr_q;
   logic [7:0] d_r, hi_byte;
   logic       sh_write;
   logic [9:0] sh_x0, x;
   logic [8:0] sh_y0, y;
   logic [1:0] sh_dec, dmask;
   logic       phase, x_full;
`ifdef CAM_TESTPATTERN_EN
   logic [1:0] sh_tp;
   logic [15:0] tp_data;
   logic [2:0]  bar;
`endif

   logic        vs_rise, vs_fall, hr_rise, hr_fall;
   logic        frame_start, frame_end, active, pix_done, hit;
   logic [9:0]  dx, wx;
   logic [8:0]  dy, wy;
   logic [31:0] wx32, wy32;
   logic [15:0] pix_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_r <= 1'b0;
         vs_q <= 1'b0;
         hr_r <= 1'b0;
         hr_q <= 1'b0;
         d_r  <= '0;
      end else begin
         vs_r <= cam_vsync;
         vs_q <= vs_r;
         hr_r <= cam_href;
         hr_q <= hr_r;
         d_r  <= cam_data;
      end
   end

   assign vs_rise     = vs_r & ~vs_q;
   assign vs_fall     = ~vs_r & vs_q;
   assign hr_rise     = hr_r & ~hr_q;
   assign hr_fall     = ~hr_r & hr_q;
   assign frame_start = (state_q == VBLANK) && vs_fall;
   assign frame_end   = (state_q == FRAME) && vs_rise;
   assign active      = (state_q == FRAME) && !vs_rise;
   // A byte arriving on the href rise is always a first byte.
   assign pix_done    = active && hr_r && phase && !hr_rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= SYNC;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SYNC:    if (vs_r)    state_d = VBLANK;
         VBLANK:  if (vs_fall) state_d = FRAME;
         FRAME:   if (vs_rise) state_d = VBLANK;
         default: state_d = SYNC;
      endcase
   end

   always_comb begin
      dmask = 2'b00;
      case (sh_dec)
         2'd0:    dmask = 2'b00;
         2'd1:    dmask = 2'b01;
         default: dmask = 2'b11;
      endcase
   end

   assign dx   = x - sh_x0;
   assign dy   = y - sh_y0;
   assign wx   = dx >> sh_dec;
   assign wy   = dy >> sh_dec;
   assign wx32 = {22'd0, wx};
   assign wy32 = {23'd0, wy};
   // Overrun pixels (x_full) are dropped so they cannot overwrite the last column.
   assign hit  = sh_write && !x_full && (x >= sh_x0) && (y >= sh_y0) &&
                 ((dx[1:0] & dmask) == 2'b00) && ((dy[1:0] & dmask) == 2'b00) &&
                 (wx32 < WIN_W_U) && (wy32 < WIN_H_U);

`ifdef CAM_TESTPATTERN_EN
   assign bar = 3'((wx32 * 32'd8) / WIN_W_U);
   always_comb begin
      tp_data = 16'hF800;
      case (sh_tp)
         2'd1: begin
            case (bar)
               3'd0:    tp_data = 16'hFFFF;
               3'd1:    tp_data = 16'hFFE0;
               3'd2:    tp_data = 16'h07FF;
               3'd3:    tp_data = 16'h07E0;
               3'd4:    tp_data = 16'hF81F;
               3'd5:    tp_data = 16'hF800;
               3'd6:    tp_data = 16'h001F;
               default: tp_data = 16'h0000;
            endcase
         end
         2'd2:    tp_data = {wx[7:0], wy[7:0]};
         default: tp_data = 16'hF800;
      endcase
   end
   assign pix_data = (sh_tp == 2'd0) ? {hi_byte, d_r} : tp_data;
`else
   assign pix_data = {hi_byte, d_r};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_write    <= 1'b0;
         sh_x0       <= '0;
         sh_y0       <= '0;
         sh_dec      <= '0;
`ifdef CAM_TESTPATTERN_EN
         sh_tp       <= '0;
`endif
         x           <= '0;
         y           <= '0;
         x_full      <= 1'b0;
         phase       <= 1'b0;
         hi_byte     <= '0;
         line_err    <= 1'b0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         frame_done  <= 1'b0;
         frame_valid <= 1'b0;
      end else begin
         wr_en      <= pix_done && hit;
         frame_done <= frame_end;
         if (frame_end && sh_write) frame_valid <= 1'b1;
         if (pix_done && hit) begin
            wr_addr <= ADDR_W'(wy32 * WIN_W_U + wx32);
            wr_data <= pix_data;
         end
         if (frame_start) begin
            sh_write <= write;
            sh_x0    <= win_x0;
            sh_y0    <= win_y0;
            sh_dec   <= (dec_shift == 2'd3) ? 2'd2 : dec_shift;
`ifdef CAM_TESTPATTERN_EN
            sh_tp    <= tp_mode;
`endif
            x        <= '0;
            y        <= '0;
            x_full   <= 1'b0;
            phase    <= 1'b0;
            line_err <= 1'b0;
         end else if (active) begin
            if (hr_r) begin
               if (!phase || hr_rise) begin
                  hi_byte <= d_r;
                  phase   <= 1'b1;
               end else begin
                  phase <= 1'b0;
                  if (x_full)          line_err <= 1'b1;
                  else if (x == X_MAX) x_full   <= 1'b1;
                  else                 x        <= x + 10'd1;
               end
            end else if (hr_fall) begin
               x      <= '0;
               x_full <= 1'b0;
               phase  <= 1'b0;
               if (phase)      line_err <= 1'b1;
               if (y != Y_MAX) y        <= y + 9'd1;
            end
         end
      end
   end

endmodule
